// File: rtl/distortion_ctrl.sv
// Control FSM for a distortion effect: key-driven preset indices, per-sample commit
// of threshold/gain, and a one-step-per-sample gain ramp on engage and disengage.
module distortion_ctrl #(
   parameter logic [15:0] THR_STEP = 16'd2048,
   parameter logic [15:0] GAIN_MAX = 16'd8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sample_valid,
   input  logic               key_toggle,
   input  logic               key_sel,
   input  logic               key_up,
   input  logic               key_down,
   output logic               on,
   output logic signed [15:0] threshold,
   output logic signed [15:0] gain,
   output logic [1:0]         state,
   output logic               sel,
   output logic               update
);

   typedef enum logic [1:0] {
      StBypass      = 2'd0,
      StEngaging    = 2'd1,
      StActive      = 2'd2,
      StDisengaging = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  thr_idx_q, thr_idx_d;
   logic [15:0] gain_idx_q, gain_idx_d;
   logic        sel_q, sel_d;
   logic        on_q, on_d;
   logic [15:0] thr_q, thr_d;
   logic [15:0] gain_q, gain_d;
   logic        upd_q, upd_d;
   logic [15:0] thr_target;

   assign thr_target = THR_STEP * ({13'd0, thr_idx_q} + 16'd1);

   // Up and down together cancel; both act on the edit target as it was before key_sel.
   always_comb begin
      thr_idx_d  = thr_idx_q;
      gain_idx_d = gain_idx_q;
      sel_d      = sel_q ^ key_sel;
      if (key_up ^ key_down) begin
         if (!sel_q) begin
            if (key_up && thr_idx_q != 3'd7) thr_idx_d = thr_idx_q + 3'd1;
            else if (key_down && thr_idx_q != 3'd0) thr_idx_d = thr_idx_q - 3'd1;
         end else begin
            if (key_up && gain_idx_q < GAIN_MAX) gain_idx_d = gain_idx_q + 16'd1;
            else if (key_down && gain_idx_q > 16'd1) gain_idx_d = gain_idx_q - 16'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      thr_d   = thr_q;
      if (sample_valid) begin
         thr_d = thr_target;
         unique case (state_q)
            StBypass: gain_d = 16'd1;
            StEngaging, StActive: begin
               if (gain_q < gain_idx_q) gain_d = gain_q + 16'd1;
               else if (gain_q > gain_idx_q) gain_d = gain_q - 16'd1;
               else if (state_q == StEngaging) state_d = StActive;
            end
            StDisengaging: begin
               if (gain_q > 16'd1) gain_d = gain_q - 16'd1;
               else state_d = StBypass;
            end
         endcase
      end
      // Toggle wins over any ramp-driven transition; the ramp step itself still applies.
      if (key_toggle) begin
         unique case (state_q)
            StBypass:             state_d = StEngaging;
            StEngaging, StActive: state_d = StDisengaging;
            StDisengaging:        state_d = StEngaging;
         endcase
      end
      on_d  = (state_d != StBypass);
      upd_d = sample_valid && ((on_d != on_q) || (thr_d != thr_q) || (gain_d != gain_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StBypass;
         thr_idx_q  <= 3'd3;
         gain_idx_q <= 16'd4;
         sel_q      <= 1'b0;
         on_q       <= 1'b0;
         thr_q      <= THR_STEP * 16'd4;
         gain_q     <= 16'd1;
         upd_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         thr_idx_q  <= thr_idx_d;
         gain_idx_q <= gain_idx_d;
         sel_q      <= sel_d;
         on_q       <= on_d;
         thr_q      <= thr_d;
         gain_q     <= gain_d;
         upd_q      <= upd_d;
      end
   end

   assign on        = on_q;
   assign threshold = thr_q;
   assign gain      = gain_q;
   assign state     = state_q;
   assign sel       = sel_q;
   assign update    = upd_q;

endmodule

// File: tb/tb_distortion_ctrl.sv
// Directed bench for distortion_ctrl: engage/disengage ramps, index saturation,
// key collisions, toggle-with-sample and asynchronous reset.
module tb_distortion_ctrl;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               sample_valid = 1'b0;
   logic               key_toggle = 1'b0;
   logic               key_sel = 1'b0;
   logic               key_up = 1'b0;
   logic               key_down = 1'b0;
   logic               on;
   logic signed [15:0] threshold;
   logic signed [15:0] gain;
   logic [1:0]         state;
   logic               sel;
   logic               update;

   int checks = 0;
   int errors = 0;

   distortion_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .key_toggle   (key_toggle),
      .key_sel      (key_sel),
      .key_up       (key_up),
      .key_down     (key_down),
      .on           (on),
      .threshold    (threshold),
      .gain         (gain),
      .state        (state),
      .sel          (sel),
      .update       (update)
   );

   always #5 clk = ~clk;

   // Hold the given inputs for one rising edge, then return 1 time unit after it.
   task automatic cyc(input logic sv, input logic tg, input logic sl, input logic up,
                      input logic dn);
      sample_valid = sv; key_toggle = tg; key_sel = sl; key_up = up; key_down = dn;
      @(posedge clk); #1;
      sample_valid = 0; key_toggle = 0; key_sel = 0; key_up = 0; key_down = 0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #2;
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
      checks++; if (on !== 1'b0) begin errors++; $display("FAIL rst_on got %0b exp 0", on); end
      checks++; if (gain !== 16'sd1) begin errors++; $display("FAIL rst_gain got %0d exp 1", gain); end
      checks++; if (threshold !== 16'sd8192) begin errors++; $display("FAIL rst_thr got %0d exp 8192", threshold); end
      checks++; if (sel !== 1'b0 || update !== 1'b0) begin errors++; $display("FAIL rst_sel_upd got %0b%0b exp 00", sel, update); end
      @(posedge clk); #1 rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_engage();
      cyc(0, 1, 0, 0, 0);
      checks++; if (state !== 2'd1 || on !== 1'b1) begin errors++; $display("FAIL eng_toggle got st=%0d on=%0b exp st=1 on=1", state, on); end
      checks++; if (gain !== 16'sd1) begin errors++; $display("FAIL eng_gain0 got %0d exp 1", gain); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd2 || update !== 1'b1) begin errors++; $display("FAIL eng_sv1 got g=%0d u=%0b exp g=2 u=1", gain, update); end
      cyc(0, 0, 0, 0, 0);
      checks++; if (update !== 1'b0) begin errors++; $display("FAIL eng_upd_pulse got %0b exp 0", update); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd3 || update !== 1'b1) begin errors++; $display("FAIL eng_sv2 got g=%0d u=%0b exp g=3 u=1", gain, update); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd4 || state !== 2'd1) begin errors++; $display("FAIL eng_sv3 got g=%0d st=%0d exp g=4 st=1", gain, state); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd4 || state !== 2'd2 || on !== 1'b1) begin errors++; $display("FAIL eng_active got g=%0d st=%0d on=%0b exp g=4 st=2 on=1", gain, state, on); end
   endtask

   task automatic test_threshold();
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
      checks++; if (threshold !== 16'sd8192) begin errors++; $display("FAIL thr_no_commit got %0d exp 8192", threshold); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (threshold !== 16'sd16384 || update !== 1'b1) begin errors++; $display("FAIL thr_max got t=%0d u=%0b exp t=16384 u=1", threshold, update); end
      checks++; if (gain !== 16'sd4) begin errors++; $display("FAIL thr_gain_hold got %0d exp 4", gain); end
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      checks++; if (threshold !== 16'sd2048) begin errors++; $display("FAIL thr_min got %0d exp 2048", threshold); end
   endtask

   task automatic test_key_collisions();
      cyc(0, 0, 0, 1, 1);
      cyc(1, 0, 0, 0, 0);
      checks++; if (threshold !== 16'sd2048 || update !== 1'b0) begin errors++; $display("FAIL both_keys got t=%0d u=%0b exp t=2048 u=0", threshold, update); end
      cyc(1, 0, 0, 1, 0);
      checks++; if (threshold !== 16'sd2048) begin errors++; $display("FAIL up_with_sv got %0d exp 2048", threshold); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (threshold !== 16'sd4096) begin errors++; $display("FAIL up_late_commit got %0d exp 4096", threshold); end
   endtask

   task automatic test_gain_sel();
      cyc(0, 0, 1, 1, 0);
      checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sel_toggle got %0b exp 1", sel); end
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0);
      checks++; if (threshold !== 16'sd6144 || gain !== 16'sd5) begin errors++; $display("FAIL sel_pretoggle got t=%0d g=%0d exp t=6144 g=5", threshold, gain); end
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd8 || state !== 2'd2) begin errors++; $display("FAIL gain_max got g=%0d st=%0d exp g=8 st=2", gain, state); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd8 || update !== 1'b0) begin errors++; $display("FAIL gain_sat got g=%0d u=%0b exp g=8 u=0", gain, update); end
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd7) begin errors++; $display("FAIL gain_step_down got %0d exp 7", gain); end
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd4 || state !== 2'd2) begin errors++; $display("FAIL gain_back got g=%0d st=%0d exp g=4 st=2", gain, state); end
      cyc(0, 0, 1, 0, 0);
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL sel_back got %0b exp 0", sel); end
   endtask

   task automatic test_disengage();
      cyc(0, 1, 0, 0, 0);
      checks++; if (state !== 2'd3 || on !== 1'b1) begin errors++; $display("FAIL dis_toggle got st=%0d on=%0b exp st=3 on=1", state, on); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd3) begin errors++; $display("FAIL dis_sv1 got %0d exp 3", gain); end
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd1 || state !== 2'd3 || on !== 1'b1) begin errors++; $display("FAIL dis_sv3 got g=%0d st=%0d on=%0b exp g=1 st=3 on=1", gain, state, on); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (state !== 2'd0 || on !== 1'b0 || gain !== 16'sd1) begin errors++; $display("FAIL dis_bypass got st=%0d on=%0b g=%0d exp st=0 on=0 g=1", state, on, gain); end
      checks++; if (update !== 1'b1) begin errors++; $display("FAIL dis_upd got %0b exp 1", update); end
   endtask

   task automatic test_reverse();
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd2 || state !== 2'd1) begin errors++; $display("FAIL rev_eng got g=%0d st=%0d exp g=2 st=1", gain, state); end
      cyc(0, 1, 0, 0, 0);
      checks++; if (state !== 2'd3 || gain !== 16'sd2) begin errors++; $display("FAIL rev_toggle got st=%0d g=%0d exp st=3 g=2", state, gain); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd1 || on !== 1'b1) begin errors++; $display("FAIL rev_sv1 got g=%0d on=%0b exp g=1 on=1", gain, on); end
      cyc(1, 0, 0, 0, 0);
      checks++; if (on !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL rev_off got on=%0b st=%0d exp on=0 st=0", on, state); end
   endtask

   task automatic test_toggle_with_sv();
      cyc(1, 1, 0, 0, 0);
      checks++; if (state !== 2'd1 || on !== 1'b1 || gain !== 16'sd1) begin errors++; $display("FAIL tgsv_eng got st=%0d on=%0b g=%0d exp st=1 on=1 g=1", state, on, gain); end
      checks++; if (update !== 1'b1) begin errors++; $display("FAIL tgsv_upd got %0b exp 1", update); end
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      checks++; if (gain !== 16'sd3 || state !== 2'd1) begin errors++; $display("FAIL tgsv_ramp got g=%0d st=%0d exp g=3 st=1", gain, state); end
   endtask

   task automatic test_reset_mid_ramp();
      #1 rst_n = 1'b0;
      #1;
      checks++; if (state !== 2'd0 || on !== 1'b0 || gain !== 16'sd1) begin errors++; $display("FAIL arst_core got st=%0d on=%0b g=%0d exp st=0 on=0 g=1", state, on, gain); end
      checks++; if (threshold !== 16'sd8192 || sel !== 1'b0 || update !== 1'b0) begin errors++; $display("FAIL arst_misc got t=%0d s=%0b u=%0b exp t=8192 s=0 u=0", threshold, sel, update); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      cyc(1, 0, 0, 0, 0);
      checks++; if (threshold !== 16'sd8192 || gain !== 16'sd1 || state !== 2'd0 || update !== 1'b0) begin errors++; $display("FAIL arst_commit got t=%0d g=%0d st=%0d u=%0b exp t=8192 g=1 st=0 u=0", threshold, gain, state, update); end
      cyc(0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0);
      checks++; if (threshold !== 16'sd10240) begin errors++; $display("FAIL arst_idx got %0d exp 10240", threshold); end
   endtask

   initial begin
      test_reset();
      test_engage();
      test_threshold();
      test_key_collisions();
      test_gain_sel();
      test_disengage();
      test_reverse();
      test_toggle_with_sv();
      test_reset_mid_ramp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/distortion_ctrl.md
DISTORTION_CTRL -- requirements
Module: distortion_ctrl

Interface
REQ-001 Parameter THR_STEP, default 16'd2048: threshold increment per preset index; threshold target = THR_STEP*(thr_idx+1).
REQ-002 Parameter GAIN_MAX, default 16'd8: largest gain target; gain_idx range 1..GAIN_MAX.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port sample_valid  input  1  one-cycle pulse per audio sample (LRCK boundary); only commit point for datapath parameters.
REQ-006 Port key_toggle  input  1  one-cycle debounced pulse; engage/disengage effect.
REQ-007 Port key_sel  input  1  one-cycle pulse; flips edit target between threshold (sel=0) and gain (sel=1).
REQ-008 Port key_up  input  1  one-cycle pulse; increments selected index.
REQ-009 Port key_down  input  1  one-cycle pulse; decrements selected index.
REQ-010 Port on  output  1  enable to distortion datapath.
REQ-011 Port threshold  output  16 signed  clip threshold to datapath.
REQ-012 Port gain  output  16 signed  current (ramped) gain to datapath.
REQ-013 Port state  output  2  FSM state: 0 BYPASS, 1 ENGAGING, 2 ACTIVE, 3 DISENGAGING.
REQ-014 Port sel  output  1  current edit target.
REQ-015 Port update  output  1  one-cycle pulse the cycle after any sample_valid commit that changed on, threshold or gain.

Function
REQ-016 All outputs registered; none combinationally dependent on inputs.
REQ-017 thr_idx 3-bit, 0..7; key_up/key_down saturate at 7/0, no wrap.
REQ-018 gain_idx 1..GAIN_MAX; key_up/key_down saturate at GAIN_MAX/1, no wrap.
REQ-019 key_up and key_down asserted same cycle: both ignored, index unchanged.
REQ-020 key_sel toggles sel on the same edge; key_up/down in that cycle act on the pre-toggle sel.
REQ-021 Index changes take effect on outputs only at a sample_valid edge; commit uses index values registered before that edge (key pulse coinciding with sample_valid commits at the following sample_valid).
REQ-022 At each sample_valid: threshold <= THR_STEP*(thr_idx+1), in every state.
REQ-023 BYPASS: on=0, gain held at 1; key_toggle -> ENGAGING with on=1 on the same edge.
REQ-024 ENGAGING: each sample_valid, gain increments by 1 toward gain_idx; when gain equals gain_idx at a sample_valid edge -> ACTIVE (gain_idx=1 reaches ACTIVE at first sample_valid).
REQ-025 ACTIVE: each sample_valid, gain steps by 1 toward gain_idx (up or down); key_toggle -> DISENGAGING.
REQ-026 DISENGAGING: each sample_valid, gain decrements by 1; at a sample_valid edge with gain=1 -> BYPASS, on=0 on that edge.
REQ-027 key_toggle in ENGAGING -> DISENGAGING immediately; in DISENGAGING -> ENGAGING immediately; gain continues from its current value, no jump.
REQ-028 key_toggle coinciding with sample_valid: ramp step for the current state applied, then transition.
REQ-029 gain never leaves range 1..GAIN_MAX; threshold never leaves THR_STEP..8*THR_STEP.

Reset
REQ-030 rst_n low asynchronously forces: state=BYPASS, on=0, gain=1, threshold=4*THR_STEP (16'd8192), thr_idx=3, gain_idx=4, sel=0, update=0.
REQ-031 Reset asserted mid-ramp abandons the ramp; after release, first sample_valid commits reset values only.

Verification
REQ-032 Reset, then key_toggle, 4 sample_valid pulses -> gain 2,3,4 then ACTIVE at gain 4; on=1 from toggle edge; update pulses each commit.
REQ-033 In ACTIVE, sel=0, key_up x6 then sample_valid -> threshold=16384 (idx saturates at 7); key_down x10 then sample_valid -> threshold=2048.
REQ-034 ACTIVE gain 4, key_toggle -> DISENGAGING; 3 sample_valid -> gain 3,2,1; 4th sample_valid -> BYPASS, on=0.
REQ-035 ENGAGING at gain 2 (target 8), key_toggle -> DISENGAGING, next sample_valid gain=1, following sample_valid on=0.
REQ-036 key_up+key_down same cycle, and key_up coinciding with sample_valid -> index unchanged / committed one sample later, respectively.
REQ-037 rst_n pulsed low during ENGAGING at gain 3 -> outputs immediately at REQ-030 values, before next clk edge.
